// File: rtl/mem_arbiter_ctrl_pkg.sv
// Shared encodings for the IF/MEM arbiter and byte-serialising RAM controller.
package mem_arbiter_ctrl_pkg;

  localparam int          RAM_W     = 8;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10
  } state_t;

  // Size code 11 is treated as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  size_bytes = 3'd1;
      SIZE_H:  size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_ctrl_ld_extend.sv
// Load extension: sign- or zero-extends a byte/half load to 32 bits; words pass through.
module mem_arbiter_ctrl_ld_extend
  import mem_arbiter_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  always_comb begin
    result = raw;
    case (size)
      SIZE_B:  result = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
      SIZE_H:  result = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Arbitrates instruction fetch and load/store onto a byte-wide single-port RAM,
// serialising multi-byte accesses against the RAM's one-cycle read latency.
module mem_arbiter_ctrl
  import mem_arbiter_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter bit FAIR_ARB = 1'b0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_done_out,
  output logic [31:0]       if_inst_out,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [1:0]        mem_size_in,
  input  logic              mem_unsigned_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [31:0]       mem_wdata_in,
  output logic              mem_done_out,
  output logic [31:0]       mem_rdata_out,
  output logic              ram_wr_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic [RAM_W-1:0]  ram_dout_out,
  input  logic [RAM_W-1:0]  ram_din_in,
  output logic [1:0]        busy_out
);

  state_t              state_q, state_d;
  logic                owner_if_q, owner_if_d;
  logic                last_mem_q, last_mem_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic [2:0]          nbytes_q, nbytes_d;
  logic                uns_q, uns_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [2:0]          step_q, step_d;
  logic [31:0]         lanes_q, lanes_d;
  logic                if_done_q, if_done_d;
  logic                mem_done_q, mem_done_d;
  logic [31:0]         if_inst_q, if_inst_d;
  logic [31:0]         mem_rdata_q, mem_rdata_d;

  logic                grant_if, grant_mem;
  logic                issuing;
  logic [31:0]         lanes_next;
  logic [31:0]         ext_data;
  logic [RAM_W-1:0]    wr_byte;

  // step_q counts cycles since the grant; byte step_q is on the bus while step_q < N,
  // and the byte presented in the previous cycle arrives on ram_din_in.
  assign issuing = (state_q != ST_IDLE) && (step_q < nbytes_q);

  always_comb begin
    lanes_next = lanes_q;
    case (step_q)
      3'd1:    lanes_next[7:0]   = ram_din_in;
      3'd2:    lanes_next[15:8]  = ram_din_in;
      3'd3:    lanes_next[23:16] = ram_din_in;
      3'd4:    lanes_next[31:24] = ram_din_in;
      default: lanes_next = lanes_q;
    endcase
  end

  always_comb begin
    case (step_q)
      3'd1:    wr_byte = wdata_q[15:8];
      3'd2:    wr_byte = wdata_q[23:16];
      3'd3:    wr_byte = wdata_q[31:24];
      default: wr_byte = wdata_q[7:0];
    endcase
  end

  mem_arbiter_ctrl_ld_extend u_ld_extend (
    .size        (size_q),
    .is_unsigned (uns_q),
    .raw         (lanes_next),
    .result      (ext_data)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      owner_if_q  <= 1'b0;
      last_mem_q  <= 1'b1;
      addr_q      <= '0;
      size_q      <= SIZE_B;
      nbytes_q    <= 3'd0;
      uns_q       <= 1'b0;
      wdata_q     <= ZERO_WORD;
      step_q      <= 3'd0;
      lanes_q     <= ZERO_WORD;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= ZERO_WORD;
      mem_rdata_q <= ZERO_WORD;
    end else if (rdy_in) begin
      state_q     <= state_d;
      owner_if_q  <= owner_if_d;
      last_mem_q  <= last_mem_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      nbytes_q    <= nbytes_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      step_q      <= step_d;
      lanes_q     <= lanes_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_if_d  = owner_if_q;
    last_mem_d  = last_mem_q;
    addr_d      = addr_q;
    size_d      = size_q;
    nbytes_d    = nbytes_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    step_d      = step_q;
    lanes_d     = lanes_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    grant_if    = 1'b0;
    grant_mem   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A done cycle is a bubble so the finished requester can drop its request.
        if (!if_done_q && !mem_done_q) begin
          if (mem_req_in && !(FAIR_ARB && if_req_in && last_mem_q)) begin
            grant_mem = 1'b1;
          end else if (if_req_in) begin
            grant_if = 1'b1;
          end
        end
        if (grant_mem) begin
          state_d    = mem_we_in ? ST_WR : ST_RD;
          owner_if_d = 1'b0;
          last_mem_d = 1'b1;
          addr_d     = mem_addr_in;
          size_d     = mem_size_in;
          nbytes_d   = size_bytes(mem_size_in);
          uns_d      = mem_unsigned_in;
          wdata_d    = mem_wdata_in;
          step_d     = 3'd0;
          lanes_d    = ZERO_WORD;
        end else if (grant_if) begin
          state_d    = ST_RD;
          owner_if_d = 1'b1;
          last_mem_d = 1'b0;
          addr_d     = if_addr_in;
          size_d     = SIZE_W;
          nbytes_d   = 3'd4;
          uns_d      = 1'b0;
          wdata_d    = ZERO_WORD;
          step_d     = 3'd0;
          lanes_d    = ZERO_WORD;
        end
      end

      ST_RD: begin
        if (owner_if_q && !if_req_in) begin
          state_d = ST_IDLE;
          step_d  = 3'd0;
        end else begin
          step_d = step_q + 3'd1;
          if (step_q != 3'd0) begin
            lanes_d = lanes_next;
          end
          if (step_q == nbytes_q) begin
            state_d = ST_IDLE;
            step_d  = 3'd0;
            if (owner_if_q) begin
              if_done_d = 1'b1;
              if_inst_d = lanes_next;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = ext_data;
            end
          end
        end
      end

      ST_WR: begin
        step_d = step_q + 3'd1;
        if (step_q == nbytes_q - 3'd1) begin
          state_d    = ST_IDLE;
          step_d     = 3'd0;
          mem_done_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign ram_addr_out  = issuing ? (addr_q + ADDR_W'(step_q)) : '0;
  assign ram_wr_out    = issuing && (state_q == ST_WR);
  assign ram_dout_out  = (issuing && (state_q == ST_WR)) ? wr_byte : '0;
  assign busy_out      = (state_q == ST_IDLE) ? 2'b00 : {owner_if_q, ~owner_if_q};
  assign if_done_out   = if_done_q;
  assign if_inst_out   = if_inst_q;
  assign mem_done_out  = mem_done_q;
  assign mem_rdata_out = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl: a strict-priority and a round-robin instance
// share one behavioural byte RAM.
module tb_mem_arbiter_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_req_in, f_if_req_in;
  logic [31:0] if_addr_in;
  logic        mem_req_in, f_mem_req_in;
  logic        mem_we_in;
  logic [1:0]  mem_size_in;
  logic        mem_unsigned_in;
  logic [31:0] mem_addr_in;
  logic [31:0] mem_wdata_in;

  logic        if_done, f_if_done;
  logic [31:0] if_inst, f_if_inst;
  logic        mem_done, f_mem_done;
  logic [31:0] mem_rdata, f_mem_rdata;
  logic        ram_wr, f_ram_wr;
  logic [31:0] ram_addr, f_ram_addr;
  logic [7:0]  ram_dout, f_ram_dout;
  logic [7:0]  ram_din, f_ram_din;
  logic [1:0]  busy, f_busy;

  logic [7:0]  ram [0:1023];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [7:0]  pre_data;

  int tests_run;
  int tests_failed;

  always #5 clk_in = ~clk_in;

  mem_arbiter_ctrl #(.ADDR_W(32), .FAIR_ARB(1'b0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in),
    .if_done_out(if_done), .if_inst_out(if_inst),
    .mem_req_in(mem_req_in), .mem_we_in(mem_we_in), .mem_size_in(mem_size_in),
    .mem_unsigned_in(mem_unsigned_in), .mem_addr_in(mem_addr_in),
    .mem_wdata_in(mem_wdata_in), .mem_done_out(mem_done), .mem_rdata_out(mem_rdata),
    .ram_wr_out(ram_wr), .ram_addr_out(ram_addr), .ram_dout_out(ram_dout),
    .ram_din_in(ram_din), .busy_out(busy)
  );

  mem_arbiter_ctrl #(.ADDR_W(32), .FAIR_ARB(1'b1)) dut_fair (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req_in(f_if_req_in), .if_addr_in(if_addr_in),
    .if_done_out(f_if_done), .if_inst_out(f_if_inst),
    .mem_req_in(f_mem_req_in), .mem_we_in(mem_we_in), .mem_size_in(mem_size_in),
    .mem_unsigned_in(mem_unsigned_in), .mem_addr_in(mem_addr_in),
    .mem_wdata_in(mem_wdata_in), .mem_done_out(f_mem_done), .mem_rdata_out(f_mem_rdata),
    .ram_wr_out(f_ram_wr), .ram_addr_out(f_ram_addr), .ram_dout_out(f_ram_dout),
    .ram_din_in(f_ram_din), .busy_out(f_busy)
  );

  // Byte RAM with one-cycle read latency, frozen together with the controller by rdy.
  always @(posedge clk_in) begin
    if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end else if (rdy_in) begin
      if (ram_wr) ram[ram_addr[9:0]] <= ram_dout;
      ram_din   <= ram[ram_addr[9:0]];
      f_ram_din <= ram[f_ram_addr[9:0]];
    end
  end

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus_load(input logic [1:0] size, input logic uns,
                                     input logic [31:0] addr, input int nbytes,
                                     input logic [31:0] expected, input string tag);
    mem_we_in       = 1'b0;
    mem_size_in     = size;
    mem_unsigned_in = uns;
    mem_addr_in     = addr;
    mem_req_in      = 1'b1;
    next_cycle();
    check_output({tag, "_busy"}, 32'(busy), 32'h1);
    check_output({tag, "_addr0"}, ram_addr, addr);
    repeat (nbytes) next_cycle();
    check_output({tag, "_early_done"}, 32'(mem_done), 32'h0);
    next_cycle();
    check_output({tag, "_done"}, 32'(mem_done), 32'h1);
    check_output({tag, "_data"}, mem_rdata, expected);
    mem_req_in = 1'b0;
    next_cycle();
    check_output({tag, "_pulse"}, 32'(mem_done), 32'h0);
  endtask

  logic [9:0]  pre_a [16];
  logic [7:0]  pre_d [16];
  logic [1:0]  exp_busy_plain [3];
  logic [1:0]  exp_busy_fair [3];

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_in = 1'b0;
    rdy_in = 1'b1;
    if_req_in = 1'b0;  f_if_req_in = 1'b0;
    mem_req_in = 1'b0; f_mem_req_in = 1'b0;
    if_addr_in = 32'h0; mem_addr_in = 32'h0; mem_wdata_in = 32'h0;
    mem_we_in = 1'b0; mem_size_in = 2'b00; mem_unsigned_in = 1'b0;
    pre_we = 1'b0; pre_addr = 10'h0; pre_data = 8'h0;
    pre_a = '{10'h100, 10'h101, 10'h102, 10'h103, 10'h020, 10'h021, 10'h022, 10'h023,
              10'h024, 10'h025, 10'h040, 10'h041, 10'h042, 10'h060, 10'h061, 10'h062};
    pre_d = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h80, 8'h11, 8'hFF, 8'h7F,
              8'h34, 8'h12, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h5C, 8'hA5};
    exp_busy_plain = '{2'b01, 2'b01, 2'b01};
    exp_busy_fair  = '{2'b10, 2'b01, 2'b10};

    // Preload RAM while the controllers sit in reset.
    for (int i = 0; i < 16; i++) begin
      pre_addr = pre_a[i];
      pre_data = pre_d[i];
      pre_we   = 1'b1;
      next_cycle();
    end
    pre_we = 1'b0;

    check_output("rst_busy", 32'(busy), 32'h0);
    check_output("rst_if_done", 32'(if_done), 32'h0);
    check_output("rst_mem_done", 32'(mem_done), 32'h0);
    check_output("rst_ram_wr", 32'(ram_wr), 32'h0);
    check_output("rst_ram_addr", ram_addr, 32'h0);
    check_output("rst_fair_busy", 32'(f_busy), 32'h0);

    rst_in = 1'b1;
    next_cycle();

    // IF word fetch from 0x100.
    if_addr_in = 32'h100;
    if_req_in  = 1'b1;
    next_cycle();
    check_output("if_busy_g1", 32'(busy), 32'h2);
    check_output("if_addr_g1", ram_addr, 32'h100);
    check_output("if_wr_g1", 32'(ram_wr), 32'h0);
    next_cycle();
    check_output("if_addr_g2", ram_addr, 32'h101);
    next_cycle();
    check_output("if_addr_g3", ram_addr, 32'h102);
    next_cycle();
    check_output("if_addr_g4", ram_addr, 32'h103);
    check_output("if_busy_g4", 32'(busy), 32'h2);
    next_cycle();
    check_output("if_done_g5", 32'(if_done), 32'h0);
    check_output("if_busy_g5", 32'(busy), 32'h2);
    next_cycle();
    check_output("if_done_g6", 32'(if_done), 32'h1);
    check_output("if_inst_g6", if_inst, 32'h0000_0013);
    check_output("if_busy_g6", 32'(busy), 32'h0);
    if_req_in = 1'b0;
    next_cycle();
    check_output("if_done_pulse", 32'(if_done), 32'h0);

    // Byte and half loads with sign/zero extension.
    apply_stimulus_load(2'b00, 1'b0, 32'h20, 1, 32'hFFFF_FF80, "lb");
    apply_stimulus_load(2'b00, 1'b1, 32'h20, 1, 32'h0000_0080, "lbu");
    apply_stimulus_load(2'b01, 1'b0, 32'h22, 2, 32'h0000_7FFF, "lh");

    // Store half 0xDEADBEEF to 0x40.
    mem_we_in    = 1'b1;
    mem_size_in  = 2'b01;
    mem_addr_in  = 32'h40;
    mem_wdata_in = 32'hDEAD_BEEF;
    mem_req_in   = 1'b1;
    next_cycle();
    check_output("sh_wr_g1", 32'(ram_wr), 32'h1);
    check_output("sh_addr_g1", ram_addr, 32'h40);
    check_output("sh_dout_g1", 32'(ram_dout), 32'hEF);
    check_output("sh_busy_g1", 32'(busy), 32'h1);
    next_cycle();
    check_output("sh_wr_g2", 32'(ram_wr), 32'h1);
    check_output("sh_addr_g2", ram_addr, 32'h41);
    check_output("sh_dout_g2", 32'(ram_dout), 32'hBE);
    next_cycle();
    check_output("sh_wr_g3", 32'(ram_wr), 32'h0);
    check_output("sh_done_g3", 32'(mem_done), 32'h1);
    mem_req_in = 1'b0;
    mem_we_in  = 1'b0;
    next_cycle();
    check_output("sh_ram40", 32'(ram[10'h040]), 32'hEF);
    check_output("sh_ram41", 32'(ram[10'h041]), 32'hBE);
    check_output("sh_ram42", 32'(ram[10'h042]), 32'h5A);

    // Both sides requesting continuously on both arbiter variants.
    mem_we_in   = 1'b0;
    mem_size_in = 2'b10;
    mem_addr_in = 32'h20;
    if_addr_in  = 32'h100;
    if_req_in = 1'b1; mem_req_in = 1'b1;
    f_if_req_in = 1'b1; f_mem_req_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      check_output($sformatf("prio_grant%0d", k), 32'(busy), 32'(exp_busy_plain[k]));
      check_output($sformatf("fair_grant%0d", k), 32'(f_busy), 32'(exp_busy_fair[k]));
      repeat (5) next_cycle();
      check_output($sformatf("prio_bubble%0d", k), 32'(busy), 32'h0);
      check_output($sformatf("prio_done%0d", k), 32'(mem_done), 32'h1);
      check_output($sformatf("prio_data%0d", k), mem_rdata, 32'h7FFF_1180);
      check_output($sformatf("fair_done%0d", k),
                   32'((exp_busy_fair[k] == 2'b10) ? f_if_done : f_mem_done), 32'h1);
      if (k == 2) begin
        if_req_in = 1'b0; mem_req_in = 1'b0;
        f_if_req_in = 1'b0; f_mem_req_in = 1'b0;
      end
      next_cycle();
      check_output($sformatf("fair_idle%0d", k), 32'(f_busy), 32'h0);
    end

    // IF abort after two bytes, MEM load takes over.
    if_addr_in  = 32'h100;
    mem_addr_in = 32'h22;
    mem_size_in = 2'b10;
    if_req_in   = 1'b1;
    next_cycle();
    check_output("abort_busy_g1", 32'(busy), 32'h2);
    next_cycle();
    check_output("abort_addr_g2", ram_addr, 32'h101);
    if_req_in  = 1'b0;
    mem_req_in = 1'b1;
    next_cycle();
    check_output("abort_busy_g3", 32'(busy), 32'h0);
    check_output("abort_ifdone_g3", 32'(if_done), 32'h0);
    next_cycle();
    check_output("abort_mem_busy", 32'(busy), 32'h1);
    check_output("abort_mem_addr", ram_addr, 32'h22);
    repeat (4) next_cycle();
    check_output("abort_mem_early", 32'(mem_done), 32'h0);
    next_cycle();
    check_output("abort_mem_done", 32'(mem_done), 32'h1);
    check_output("abort_mem_data", mem_rdata, 32'h1234_7FFF);
    check_output("abort_no_ifdone", 32'(if_done), 32'h0);
    mem_req_in = 1'b0;
    next_cycle();

    // rdy low for three cycles in the middle of a fetch.
    if_addr_in = 32'h100;
    if_req_in  = 1'b1;
    next_cycle();
    next_cycle();
    rdy_in = 1'b0;
    for (int s = 0; s < 3; s++) begin
      next_cycle();
      check_output($sformatf("stall_addr%0d", s), ram_addr, 32'h101);
    end
    rdy_in = 1'b1;
    repeat (3) next_cycle();
    check_output("stall_done_early", 32'(if_done), 32'h0);
    next_cycle();
    check_output("stall_done", 32'(if_done), 32'h1);
    check_output("stall_inst", if_inst, 32'h0000_0013);
    if_req_in = 1'b0;
    next_cycle();

    // Reset mid-store: word to 0x60, reset during the second byte.
    mem_we_in    = 1'b1;
    mem_size_in  = 2'b10;
    mem_addr_in  = 32'h60;
    mem_wdata_in = 32'h1122_3344;
    mem_req_in   = 1'b1;
    next_cycle();
    check_output("rstwr_dout_g1", 32'(ram_dout), 32'h44);
    next_cycle();
    check_output("rstwr_addr_g2", ram_addr, 32'h61);
    #2;
    rst_in = 1'b0;
    #1;
    check_output("rstwr_ram_wr", 32'(ram_wr), 32'h0);
    check_output("rstwr_ram_addr", ram_addr, 32'h0);
    check_output("rstwr_ram_dout", 32'(ram_dout), 32'h0);
    check_output("rstwr_busy", 32'(busy), 32'h0);
    check_output("rstwr_rdata", mem_rdata, 32'h0);
    check_output("rstwr_inst", if_inst, 32'h0);
    mem_req_in = 1'b0;
    mem_we_in  = 1'b0;
    next_cycle();
    check_output("rstwr_ram60", 32'(ram[10'h060]), 32'h44);
    check_output("rstwr_ram61", 32'(ram[10'h061]), 32'h5C);
    check_output("rstwr_ram62", 32'(ram[10'h062]), 32'hA5);
    rst_in = 1'b1;
    next_cycle();
    check_output("post_rst_busy", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
